// File: rtl/jts16_sdram_pkg.sv
// Shared types and constants for the S16 SDRAM request scheduler.
package jts16_sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Which requester owns the outstanding transaction
  typedef enum logic [1:0] {
    OWN_BANK = 2'd0,
    OWN_PROG = 2'd1,
    OWN_RFSH = 2'd2
  } owner_t;

  localparam logic [1:0] BA_VRAM = 2'd0;  // VRAM / ROM
  localparam logic [1:0] BA_SND  = 2'd1;  // sound
  localparam logic [1:0] BA_TILE = 2'd2;  // tiles
  localparam logic [1:0] BA_OBJ  = 2'd3;  // objects

  // 7.8 us at 48 MHz
  localparam int unsigned REFRESH_CNT_DEF = 374;

endpackage

// File: rtl/jts16_rr_pick.sv
// Combinational 4-way round-robin picker: searches from last+1 (mod 4).
module jts16_rr_pick (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  logic [1:0] cand;

  // First requester after last, wrapping; last itself is checked last
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_i + 2'(i);
      if (!valid_o && req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jts16_sdram_sched.sv
// Single-port SDRAM scheduler: serialises bank, programming and refresh
// transactions towards one controller command port.
module jts16_sdram_sched
  import jts16_sdram_pkg::*;
#(
  parameter int unsigned AW          = 22,
  parameter int unsigned REFRESH_CNT = REFRESH_CNT_DEF,
  parameter int unsigned REFRESH_MAX = 4
) (
  input  logic          rst,
  input  logic          clk,
  input  logic [3:0]    ba_rd,
  input  logic          ba0_wr,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_rdy,
  input  logic          refresh_en,
  input  logic          downloading,
  input  logic          prog_we,
  input  logic          prog_rd,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ba,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  output logic          prog_ack,
  output logic          prog_rdy,
  output logic          sd_req,
  output logic [1:0]    sd_ba,
  output logic [AW-1:0] sd_addr,
  output logic          sd_wr,
  output logic          sd_rfsh,
  output logic [15:0]   sd_din,
  output logic [1:0]    sd_din_m,
  input  logic          sd_gnt,
  input  logic          sd_done
);

  localparam int unsigned CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam int unsigned DW = $clog2(REFRESH_MAX + 1);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    sd_ba_q, sd_ba_d;
  logic [AW-1:0] sd_addr_q, sd_addr_d;
  logic          sd_wr_q, sd_wr_d;
  logic          sd_rfsh_q, sd_rfsh_d;
  logic [15:0]   sd_din_q, sd_din_d;
  logic [1:0]    sd_din_m_q, sd_din_m_d;
  logic [3:0]    ack_q, ack_d, rdy_q, rdy_d;
  logic          pack_q, pack_d, prdy_q, prdy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] debt_q, debt_d;

  logic [3:0] bank_req;
  logic [1:0] rr_idx;
  logic       rr_valid;
  logic       sel_prog, sel_rfsh, sel_bank, start;
  logic       gnt_ok, done_ok, wrap, rfsh_gnt;

  assign bank_req = {ba_rd[3:1], ba_rd[0] | ba0_wr};

  jts16_rr_pick u_pick (
    .req_i   (bank_req),
    .last_i  (last_q),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  assign sel_prog = downloading & (prog_we | prog_rd);
  assign sel_rfsh = ~downloading & (debt_q != '0) & refresh_en;
  assign sel_bank = ~downloading & ~sel_rfsh & rr_valid;
  assign start    = (state_q == ST_IDLE) & (sel_prog | sel_rfsh | sel_bank);
  // A done in the grant cycle completes the transaction; a done before it is ignored
  assign gnt_ok   = (state_q == ST_ISSUE) & sd_gnt;
  assign done_ok  = ((state_q == ST_WAIT) & sd_done) | (gnt_ok & sd_done);
  assign wrap     = (cnt_q == CW'(REFRESH_CNT - 1));
  assign rfsh_gnt = gnt_ok & (owner_q == OWN_RFSH);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (sd_gnt) state_d = sd_done ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (sd_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    sd_req = (state_q == ST_ISSUE);
  end

  // Command latching, handshake pulses and refresh debt bookkeeping
  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    sd_ba_d    = sd_ba_q;
    sd_addr_d  = sd_addr_q;
    sd_wr_d    = sd_wr_q;
    sd_rfsh_d  = sd_rfsh_q;
    sd_din_d   = sd_din_q;
    sd_din_m_d = sd_din_m_q;
    if (start) begin
      if (sel_prog) begin
        owner_d    = OWN_PROG;
        sd_ba_d    = prog_ba;
        sd_addr_d  = prog_addr;
        sd_wr_d    = prog_we;
        sd_rfsh_d  = 1'b0;
        sd_din_d   = prog_data;
        sd_din_m_d = prog_mask;
      end else if (sel_rfsh) begin
        owner_d    = OWN_RFSH;
        sd_ba_d    = '0;
        sd_addr_d  = '0;
        sd_wr_d    = 1'b0;
        sd_rfsh_d  = 1'b1;
        sd_din_d   = '0;
        sd_din_m_d = '0;
      end else begin
        owner_d    = OWN_BANK;
        last_d     = rr_idx;
        sd_ba_d    = rr_idx;
        sd_rfsh_d  = 1'b0;
        sd_wr_d    = (rr_idx == BA_VRAM) & ba0_wr;
        sd_din_d   = (rr_idx == BA_VRAM) ? ba0_din : '0;
        sd_din_m_d = (rr_idx == BA_VRAM) ? ba0_din_m : '0;
        case (rr_idx)
          BA_VRAM: sd_addr_d = ba0_addr;
          BA_SND:  sd_addr_d = ba1_addr;
          BA_TILE: sd_addr_d = ba2_addr;
          BA_OBJ:  sd_addr_d = ba3_addr;
          default: sd_addr_d = ba0_addr;
        endcase
      end
    end

    ack_d = '0;
    rdy_d = '0;
    if (gnt_ok  && owner_q == OWN_BANK) ack_d[sd_ba_q] = 1'b1;
    if (done_ok && owner_q == OWN_BANK) rdy_d[sd_ba_q] = 1'b1;
    pack_d = gnt_ok  & (owner_q == OWN_PROG);
    prdy_d = done_ok & (owner_q == OWN_PROG);

    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    debt_d = debt_q;
    if (wrap && !rfsh_gnt) begin
      if (debt_q < DW'(REFRESH_MAX)) debt_d = debt_q + DW'(1);
    end else if (!wrap && rfsh_gnt) begin
      debt_d = debt_q - DW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_BANK;
      last_q     <= 2'd3;
      sd_ba_q    <= '0;
      sd_addr_q  <= '0;
      sd_wr_q    <= 1'b0;
      sd_rfsh_q  <= 1'b0;
      sd_din_q   <= '0;
      sd_din_m_q <= '0;
      ack_q      <= '0;
      rdy_q      <= '0;
      pack_q     <= 1'b0;
      prdy_q     <= 1'b0;
      cnt_q      <= '0;
      debt_q     <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      sd_ba_q    <= sd_ba_d;
      sd_addr_q  <= sd_addr_d;
      sd_wr_q    <= sd_wr_d;
      sd_rfsh_q  <= sd_rfsh_d;
      sd_din_q   <= sd_din_d;
      sd_din_m_q <= sd_din_m_d;
      ack_q      <= ack_d;
      rdy_q      <= rdy_d;
      pack_q     <= pack_d;
      prdy_q     <= prdy_d;
      cnt_q      <= cnt_d;
      debt_q     <= debt_d;
    end
  end

  assign sd_ba    = sd_ba_q;
  assign sd_addr  = sd_addr_q;
  assign sd_wr    = sd_wr_q;
  assign sd_rfsh  = sd_rfsh_q;
  assign sd_din   = sd_din_q;
  assign sd_din_m = sd_din_m_q;
  assign ba_ack   = ack_q;
  assign ba_rdy   = rdy_q;
  assign prog_ack = pack_q;
  assign prog_rdy = prdy_q;

endmodule

// File: tb/tb_jts16_sdram_sched.sv
// Directed bench for jts16_sdram_sched with hand-computed expectations.
module tb_jts16_sdram_sched;

  logic        rst, clk;
  logic [3:0]  ba_rd;
  logic        ba0_wr;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [15:0] ba0_din;
  logic [1:0]  ba0_din_m;
  logic [3:0]  ba_ack, ba_rdy;
  logic        refresh_en, downloading, prog_we, prog_rd;
  logic [21:0] prog_addr;
  logic [1:0]  prog_ba;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_ack, prog_rdy;
  logic        sd_req, sd_wr, sd_rfsh, sd_gnt, sd_done;
  logic [1:0]  sd_ba, sd_din_m;
  logic [21:0] sd_addr;
  logic [15:0] sd_din;

  int total = 0;
  int bad   = 0;

  // controller-model state
  int          cyc;
  int          nrdy;
  logic        req_prev;
  int          q_cyc[$];
  logic        q_rf[$];
  logic [1:0]  q_ba[$];

  jts16_sdram_sched #(.AW(22), .REFRESH_CNT(8), .REFRESH_MAX(4)) dut (
    .rst(rst), .clk(clk), .ba_rd(ba_rd), .ba0_wr(ba0_wr),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba0_din(ba0_din), .ba0_din_m(ba0_din_m), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .refresh_en(refresh_en), .downloading(downloading), .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy), .sd_req(sd_req), .sd_ba(sd_ba),
    .sd_addr(sd_addr), .sd_wr(sd_wr), .sd_rfsh(sd_rfsh), .sd_din(sd_din),
    .sd_din_m(sd_din_m), .sd_gnt(sd_gnt), .sd_done(sd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One cycle of a controller that grants immediately and completes one cycle later
  task automatic ctl_cycle();
    step();
    cyc++;
    if (sd_req && !req_prev) begin
      q_cyc.push_back(cyc);
      q_rf.push_back(sd_rfsh);
      q_ba.push_back(sd_ba);
    end
    req_prev = sd_req;
    if (ba_rdy != 4'b0) nrdy++;
    ba_rd   = ba_rd & ~ba_ack;
    sd_done = sd_gnt;
    sd_gnt  = sd_req;
  endtask

  task automatic ctl_run(input int n);
    for (int i = 0; i < n; i++) ctl_cycle();
  endtask

  initial begin
    logic [3:0]  oh;
    logic [21:0] addr_tab [4];
    int          j;

    rst = 1'b1; ba_rd = '0; ba0_wr = 1'b0;
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    ba0_din = '0; ba0_din_m = '0; refresh_en = 1'b0; downloading = 1'b0;
    prog_we = 1'b0; prog_rd = 1'b0; prog_addr = '0; prog_ba = '0;
    prog_data = '0; prog_mask = '0; sd_gnt = 1'b0; sd_done = 1'b0;
    step(); step();
    chk("rst_sd_req", sd_req, 0);
    chk("rst_ack", ba_ack, 0);
    rst = 1'b0;

    // ---- reset while a transaction is outstanding ----
    ba_rd = 4'b0010; ba1_addr = 22'h00_0055;
    step();
    chk("rs_req", sd_req, 1);
    chk("rs_ba", sd_ba, 1);
    chk("rs_addr", sd_addr, 22'h00_0055);
    sd_gnt = 1'b1;
    step();
    chk("rs_ack", ba_ack, 4'b0010);
    sd_gnt = 1'b0; ba_rd = '0;
    #2 rst = 1'b1;
    #1;
    chk("rs_async_ack", ba_ack, 0);
    chk("rs_async_addr", sd_addr, 0);
    chk("rs_async_ba", sd_ba, 0);
    chk("rs_async_req", sd_req, 0);
    step();
    rst = 1'b0;
    ba_rd = 4'b0001; ba0_addr = 22'h10_0004;
    step();
    chk("rs_first_req", sd_req, 1);
    chk("rs_first_ba", sd_ba, 0);
    chk("rs_first_addr", sd_addr, 22'h10_0004);
    sd_gnt = 1'b1;
    step();
    chk("rs_first_ack", ba_ack, 4'b0001);
    ba_rd = '0; sd_gnt = 1'b0; sd_done = 1'b1;
    step();
    chk("rs_first_rdy", ba_rdy, 4'b0001);
    sd_done = 1'b0;
    step();

    // ---- round-robin, grant and done two cycles after request ----
    do_reset();
    addr_tab[0] = 22'h00_00A0; addr_tab[1] = 22'h00_0111;
    addr_tab[2] = 22'h00_0222; addr_tab[3] = 22'h00_0333;
    ba0_addr = addr_tab[0]; ba1_addr = addr_tab[1];
    ba2_addr = addr_tab[2]; ba3_addr = addr_tab[3];
    ba_rd = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      chk("rr_req", sd_req, 1);
      chk("rr_ba", sd_ba, 64'(k % 4));
      chk("rr_addr", sd_addr, addr_tab[k % 4]);
      chk("rr_rd", sd_wr, 0);
      step();
      chk("rr_no_ack_yet", ba_ack, 0);
      sd_gnt = 1'b1;
      step();
      chk("rr_ack", ba_ack, oh);
      chk("rr_req_drop", sd_req, 0);
      sd_gnt = 1'b0;
      step();
      chk("rr_ack_1cyc", ba_ack, 0);
      sd_done = 1'b1;
      step();
      chk("rr_rdy", ba_rdy, oh);
      sd_done = 1'b0;
      if (k == 4) ba_rd = '0;
      step();
      chk("rr_rdy_1cyc", ba_rdy, 0);
    end
    chk("rr_idle", sd_req, 0);

    // ---- bank 0 write wins over read ----
    ba_rd = 4'b0001; ba0_wr = 1'b1; ba0_din = 16'hBEEF; ba0_din_m = 2'b10;
    ba0_addr = 22'h00_0777;
    step();
    chk("wr_req", sd_req, 1);
    chk("wr_wr", sd_wr, 1);
    chk("wr_din", sd_din, 16'hBEEF);
    chk("wr_mask", sd_din_m, 2'b10);
    chk("wr_addr", sd_addr, 22'h00_0777);
    sd_gnt = 1'b1;
    step();
    chk("wr_ack", ba_ack, 4'b0001);
    ba_rd = '0; ba0_wr = 1'b0; sd_gnt = 1'b0; sd_done = 1'b1;
    step();
    chk("wr_rdy", ba_rdy, 4'b0001);
    sd_done = 1'b0;
    step();
    chk("wr_idle", sd_req, 0);

    // ---- download: only prog port served ----
    downloading = 1'b1; ba_rd = 4'b0110; prog_we = 1'b1; prog_ba = 2'd2;
    prog_addr = 22'h00_0100; prog_data = 16'h1234; prog_mask = 2'b01;
    step();
    chk("dl_req", sd_req, 1);
    chk("dl_wr", sd_wr, 1);
    chk("dl_ba", sd_ba, 2);
    chk("dl_addr", sd_addr, 22'h00_0100);
    chk("dl_data", sd_din, 16'h1234);
    chk("dl_mask", sd_din_m, 2'b01);
    sd_gnt = 1'b1;
    step();
    chk("dl_pack", prog_ack, 1);
    chk("dl_no_back", ba_ack, 0);
    prog_we = 1'b0; sd_gnt = 1'b0; sd_done = 1'b1;
    step();
    chk("dl_prdy", prog_rdy, 1);
    chk("dl_no_brdy", ba_rdy, 0);
    sd_done = 1'b0;
    step();
    chk("dl_banks_held", sd_req, 0);
    downloading = 1'b0;
    step();
    chk("dl_after_req", sd_req, 1);
    chk("dl_after_ba", sd_ba, 1);
    chk("dl_after_addr", sd_addr, 22'h00_0111);

    // ---- grant and done in the same cycle ----
    sd_gnt = 1'b1; sd_done = 1'b1;
    step();
    chk("gd_ack", ba_ack, 4'b0010);
    chk("gd_rdy", ba_rdy, 4'b0010);
    chk("gd_req_low", sd_req, 0);
    ba_rd = 4'b0100; sd_gnt = 1'b0; sd_done = 1'b0;
    step();
    chk("gd_next_req", sd_req, 1);
    chk("gd_next_ba", sd_ba, 2);
    chk("gd_ack_clear", ba_ack, 0);
    // done without a grant is ignored
    sd_done = 1'b1;
    step();
    chk("ng_rdy", ba_rdy, 0);
    chk("ng_req_held", sd_req, 1);
    sd_done = 1'b0; sd_gnt = 1'b1;
    step();
    chk("ng_ack", ba_ack, 4'b0100);
    ba_rd = '0; sd_gnt = 1'b0; sd_done = 1'b1;
    step();
    chk("ng_rdy2", ba_rdy, 4'b0100);
    sd_done = 1'b1;
    step();
    chk("idle_done_ignored", ba_rdy, 0);
    chk("idle_no_req", sd_req, 0);
    sd_done = 1'b0;

    // ---- refresh: steady state every 8 cycles ----
    cyc = 0; nrdy = 0; req_prev = sd_req;
    refresh_en = 1'b1;
    ctl_run(40);
    q_cyc.delete(); q_rf.delete(); q_ba.delete();
    nrdy = 0;
    ctl_run(32);
    chk("rf_count", q_cyc.size(), 4);
    if (q_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("rf_period", q_cyc[i] - q_cyc[i-1], 8);
      for (int i = 0; i < 4; i++) chk("rf_flag", q_rf[i], 1);
    end
    chk("rf_no_rdy", nrdy, 0);

    // ---- refresh: saturated debt drains before pending bank 2 ----
    refresh_en = 1'b0;
    ctl_run(40);
    q_cyc.delete(); q_rf.delete(); q_ba.delete();
    nrdy = 0;
    ba_rd = 4'b0100;
    refresh_en = 1'b1;
    ctl_run(60);
    j = -1;
    for (int i = 0; i < q_rf.size(); i++)
      if (j < 0 && !q_rf[i]) j = i;
    chk("sat_bank_served", j >= 0, 1);
    chk("sat_four_rfsh_first", j >= 4, 1);
    if (j >= 0) chk("sat_bank_ba", q_ba[j], 2);
    chk("sat_one_rdy", nrdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
